suna_blink: RTL and testbench

Parametrised multi-channel LED/buzzer driver. It replaces the single-channel toggler in the indicator path. A shared prescaler generates a half-period tick. Each channel is enabled by its own `semnal` bit and runs in one of four modes: off, steady, continuous blink, or counted burst with a completion pulse. All outputs are registered and sit directly on board LED/buzzer pins.

---
 rtl/suna_pkg.sv | 17 +
 rtl/suna_blink_if.sv | 15 +
 rtl/suna_channel.sv | 96 +++++++++
 rtl/suna_blink.sv | 49 ++++
 tb/tb_suna_blink.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/suna_pkg.sv
// Shared types and mode encodings for the suna_blink multi-channel indicator driver.
package suna_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEADY,
    ST_BLINK,
    ST_BURST,
    ST_HOLD
  } state_t;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_STEADY = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_BURST  = 2'b11;

endpackage

// File: rtl/suna_blink_if.sv
// Per-channel control/status bundle between the indicator controller and suna_blink.
interface suna_blink_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]       semnal;
  logic [2*CHANNELS-1:0]     mode;
  logic [CNT_W*CHANNELS-1:0] burst_len;
  logic [CHANNELS-1:0]       led;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS-1:0]       done;

  modport master (output semnal, mode, burst_len, input  led, busy, done);
  modport slave  (input  semnal, mode, burst_len, output led, busy, done);
endinterface

// File: rtl/suna_channel.sv
// One indicator channel: off / steady / blink / counted burst, stepped by the shared tick.
module suna_channel
  import suna_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_tick,
  input  logic             i_semnal,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_led,
  output logic             o_busy,
  output logic             o_done
);

  state_t           r_state, w_state_nxt;
  logic             r_led, w_led_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
    r_rem <= w_rem_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_done_nxt  = 1'b0;
    w_rem_nxt   = r_rem;
    // Dropping the enable wins over everything, including a pending burst completion.
    if (!i_semnal) begin
      w_state_nxt = ST_IDLE;
      w_led_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_rem_nxt = i_len;
          case (i_mode)
            MODE_STEADY: begin w_state_nxt = ST_STEADY; w_led_nxt = 1'b1; end
            MODE_BLINK:  begin w_state_nxt = ST_BLINK;  w_led_nxt = 1'b1; end
            MODE_BURST: begin
              if (i_len != '0) begin
                w_state_nxt = ST_BURST;
                w_led_nxt   = 1'b1;
              end else begin
                w_state_nxt = ST_HOLD;
                w_led_nxt   = 1'b0;
                w_done_nxt  = 1'b1;
              end
            end
            default: begin w_state_nxt = ST_HOLD; w_led_nxt = 1'b0; end
          endcase
        end
        ST_STEADY: w_led_nxt = 1'b1;
        ST_BLINK:  if (i_tick) w_led_nxt = !r_led;
        ST_BURST: begin
          if (i_tick) begin
            if (r_led) begin
              w_led_nxt = 1'b0;
              if (r_rem != '0) w_rem_nxt = r_rem - 1'b1;
              if (r_rem <= CNT_W'(1)) begin
                w_state_nxt = ST_HOLD;
                w_done_nxt  = 1'b1;
              end
            end else begin
              w_led_nxt = 1'b1;
            end
          end
        end
        ST_HOLD:  w_led_nxt = 1'b0;
        default: begin w_state_nxt = ST_IDLE; w_led_nxt = 1'b0; end
      endcase
    end
    w_busy_nxt = (w_state_nxt == ST_STEADY) || (w_state_nxt == ST_BLINK) ||
                 (w_state_nxt == ST_BURST);
  end

  assign o_led  = r_led;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/suna_blink.sv
// Multi-channel LED/buzzer driver: free-running half-period prescaler feeding CHANNELS channel FSMs.
module suna_blink
  import suna_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int HALF_PERIOD = 25_000_000,
  parameter int DIV_W       = 25,
  parameter int CNT_W       = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  suna_blink_if.slave bus
);

  logic [DIV_W-1:0]    r_div;
  logic                w_tick;
  logic [CHANNELS-1:0] w_led, w_busy, w_done;

  assign w_tick = (r_div == DIV_W'(HALF_PERIOD - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    suna_channel #(.CNT_W(CNT_W)) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_tick   (w_tick),
      .i_semnal (bus.semnal[g]),
      .i_mode   (bus.mode[2*g +: 2]),
      .i_len    (bus.burst_len[CNT_W*g +: CNT_W]),
      .o_led    (w_led[g]),
      .o_busy   (w_busy[g]),
      .o_done   (w_done[g])
    );
  end

  assign bus.led  = w_led;
  assign bus.busy = w_busy;
  assign bus.done = w_done;

endmodule

// File: tb/tb_suna_blink.sv
// Bench for suna_blink: directed scenarios then random traffic, checked against a phase-count model.
module tb_suna_blink;
  localparam int CH = 4;
  localparam int HP = 4;
  localparam int DW = 3;
  localparam int CW = 8;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  suna_blink_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  suna_blink #(.CHANNELS(CH), .HALF_PERIOD(HP), .DIV_W(DW), .CNT_W(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a channel is either inactive or active with a latched mode/length
  // and a count k of ticks seen since entry; outputs follow arithmetically from k.
  bit m_act  [CH];
  int m_mode [CH];
  int m_len  [CH];
  int m_k    [CH];
  bit m_done [CH];
  int pc = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int end_k(input int len);
    return (len == 0) ? 0 : 2 * len - 1;
  endfunction

  task automatic set_ch(input int i, input bit s, input logic [1:0] m, input int len);
    logic [CW-1:0] l;
    l = len[CW-1:0];
    bus.semnal[i]          = s;
    bus.mode[2*i +: 2]     = m;
    bus.burst_len[CW*i +: CW] = l;
  endtask

  task automatic step();
    bit t;
    int sem, md, ln, e_led, e_busy;
    @(posedge clock);
    t = (pc == HP - 1);
    if (!reset_n) begin
      pc = 0;
      for (int i = 0; i < CH; i++) begin m_act[i] = 0; m_done[i] = 0; end
    end else begin
      pc = (pc + 1) % HP;
      for (int i = 0; i < CH; i++) begin
        sem = int'(bus.semnal[i]);
        md  = int'(bus.mode[2*i +: 2]);
        ln  = int'(bus.burst_len[CW*i +: CW]);
        m_done[i] = 0;
        if (!m_act[i]) begin
          if (sem != 0) begin
            m_act[i] = 1; m_mode[i] = md; m_len[i] = ln; m_k[i] = 0;
            m_done[i] = (md == 3) && (ln == 0);
          end
        end else if (sem == 0) begin
          m_act[i] = 0;
        end else if (t) begin
          if (m_mode[i] == 2) m_k[i]++;
          else if (m_mode[i] == 3 && m_k[i] < end_k(m_len[i])) begin
            m_k[i]++;
            m_done[i] = (m_k[i] == end_k(m_len[i]));
          end
        end
      end
    end
    #1;
    for (int i = 0; i < CH; i++) begin
      e_led = 0; e_busy = 0;
      if (m_act[i]) begin
        case (m_mode[i])
          1: begin e_led = 1; e_busy = 1; end
          2: begin e_led = (m_k[i] % 2 == 0) ? 1 : 0; e_busy = 1; end
          3: if (m_k[i] < end_k(m_len[i])) begin
               e_led = (m_k[i] % 2 == 0) ? 1 : 0; e_busy = 1;
             end
          default: ;
        endcase
      end
      check($sformatf("led%0d", i),  int'(bus.led[i]),  e_led);
      check($sformatf("busy%0d", i), int'(bus.busy[i]), e_busy);
      check($sformatf("done%0d", i), int'(bus.done[i]), int'(m_done[i]));
    end
  endtask

  initial begin
    int pulses2, done2, done3, hi;
    bit prev2;
    reset_n       = 1'b0;
    bus.semnal    = '0;
    bus.mode      = '0;
    bus.burst_len = '0;
    set_ch(0, 1, 2'b01, 0);
    set_ch(1, 1, 2'b10, 0);
    set_ch(2, 1, 2'b11, 3);
    set_ch(3, 1, 2'b11, 3);
    repeat (3) step();
    reset_n = 1'b1;

    pulses2 = 0; done2 = 0; done3 = 0; prev2 = 0;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (bus.led[2] && !prev2) pulses2++;
      prev2 = bus.led[2];
      done2 += int'(bus.done[2]);
      done3 += int'(bus.done[3]);
      if (j == 14) bus.semnal[3] = 1'b0;
      if (j == 16) set_ch(3, 1, 2'b11, 1);
      if (j == 20) bus.mode[3:2] = 2'b01;
    end
    check("ch2_pulses", pulses2, 3);
    check("ch2_done_cnt", done2, 1);
    check("ch3_done_cnt", done3, 1);

    bus.semnal = '0;
    step();
    set_ch(0, 1, 2'b11, 0);
    step();
    check("len0_done", int'(bus.done[0]), 1);
    bus.semnal[0] = 1'b0;
    step();

    for (int g = 0; g < HP && pc != HP - 1; g++) step();
    set_ch(1, 1, 2'b10, 0);
    step();
    hi = 0;
    for (int j = 0; j < 8 && bus.led[1]; j++) begin
      hi++;
      step();
    end
    check("align_first_half", hi, 4);
    bus.semnal = '0;
    step();

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        bus.mode[2*i +: 2] = 2'($urandom_range(0, 3));
        bus.burst_len[CW*i +: CW] = CW'($urandom_range(0, 3));
        if ($urandom_range(0, 31) == 0) bus.semnal[i] = ~bus.semnal[i];
      end
      reset_n = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
